// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: opcodes, register numbers, exception codes and the vector.
// No logic; imported by the CP0 register block and its bench.
package cp0_regs_pkg;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_SYS  = 2'b11;

  localparam logic [4:0] CS_COUNT  = 5'd9;
  localparam logic [4:0] CS_STATUS = 5'd12;
  localparam logic [4:0] CS_CAUSE  = 5'd13;
  localparam logic [4:0] CS_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_8000;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } cp0_state_e;

  function automatic logic cp0_hit(input logic [4:0] cs, input logic [2:0] sel,
                                   input logic [4:0] want);
    return (sel == 3'd0) && (cs == want);
  endfunction

endpackage

// File: rtl/cp0_regs_if.sv
// Pipeline-facing CP0 bundle: ID op/PC, EPC forwarding, WB commit, MFC0 read and redirect.
// Purely combinational wiring; no flow control.
interface cp0_regs_if;
  logic [2:0]  idCp0Op;
  logic [31:0] idPc;
  logic [1:0]  cp0Forward;
  logic [31:0] exFwdData;
  logic [31:0] memFwdData;
  logic        wbWe;
  logic [4:0]  wbCs;
  logic [2:0]  wbSel;
  logic [31:0] wbData;
  logic [4:0]  rdCs;
  logic [2:0]  rdSel;
  logic [31:0] rdata;
  logic        intReq;
  logic        excTaken;
  logic [31:0] excTarget;
  logic [31:0] statusOut;

  modport master (
    output idCp0Op, idPc, cp0Forward, exFwdData, memFwdData,
    output wbWe, wbCs, wbSel, wbData, rdCs, rdSel, intReq,
    input  rdata, excTaken, excTarget, statusOut
  );

  modport slave (
    input  idCp0Op, idPc, cp0Forward, exFwdData, memFwdData,
    input  wbWe, wbCs, wbSel, wbData, rdCs, rdSel, intReq,
    output rdata, excTaken, excTarget, statusOut
  );
endinterface

// File: rtl/cp0_epc_mux.sv
// EPC source select: forwarded MTC0 data from EX or MEM, else the stored EPC.
// Combinational, zero latency.
module cp0_epc_mux
  import cp0_regs_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_ex_dat,
  input  logic [31:0] i_mem_dat,
  input  logic [31:0] i_epc,
  output logic [31:0] o_epc
);

  always_comb begin
    o_epc = i_epc;
    case (i_sel)
      FWD_EX:  o_epc = i_ex_dat;
      FWD_MEM: o_epc = i_mem_dat;
      default: o_epc = i_epc;
    endcase
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 Count/Status/Cause/EPC with SYSCALL, ERET and interrupt redirect; redirect is same-cycle,
// register updates land on the next edge. Never stalls the pipeline.
module cp0_regs
  import cp0_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cp0_regs_if.slave  bus
);

  cp0_state_e  r_state;
  cp0_state_e  w_state_nxt;
  logic [31:0] r_count;
  logic        r_status_ie;
  logic [31:2] r_status_hi;
  logic [31:0] r_cause;
  logic [31:0] r_epc;

  logic        w_eret;
  logic        w_sys;
  logic        w_irq;
  logic        w_wb_count;
  logic        w_wb_status;
  logic        w_wb_cause;
  logic        w_wb_epc;
  logic [31:0] w_epc_out;
  logic [31:0] w_status;
  logic [31:0] w_cause_nxt;
  logic [31:0] w_epc_nxt;

  // Events are masked during reset so no redirect escapes while rst is held.
  assign w_eret = !rst && (bus.idCp0Op == OP_ERET);
  assign w_sys  = !rst && (bus.idCp0Op == OP_SYSCALL);
  assign w_irq  = !rst && bus.intReq && r_status_ie && (r_state == ST_RUN) &&
                  (bus.idCp0Op == OP_NONE);

  assign w_wb_count  = bus.wbWe && cp0_hit(bus.wbCs, bus.wbSel, CS_COUNT);
  assign w_wb_status = bus.wbWe && cp0_hit(bus.wbCs, bus.wbSel, CS_STATUS);
  assign w_wb_cause  = bus.wbWe && cp0_hit(bus.wbCs, bus.wbSel, CS_CAUSE);
  assign w_wb_epc    = bus.wbWe && cp0_hit(bus.wbCs, bus.wbSel, CS_EPC);

  // EXL is the FSM state itself, so the two can never disagree.
  assign w_status      = {r_status_hi, (r_state == ST_EXC), r_status_ie};
  assign bus.statusOut = w_status;

  cp0_epc_mux u_epc_mux (
    .i_sel     (bus.cp0Forward),
    .i_ex_dat  (bus.exFwdData),
    .i_mem_dat (bus.memFwdData),
    .i_epc     (r_epc),
    .o_epc     (w_epc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_eret)           w_state_nxt = ST_RUN;
    else if (w_sys)       w_state_nxt = ST_EXC;
    else if (w_irq)       w_state_nxt = ST_EXC;
    else if (w_wb_status) w_state_nxt = cp0_state_e'(bus.wbData[1]);
  end

  always_comb begin
    bus.excTaken  = 1'b0;
    bus.excTarget = 32'h0;
    if (w_eret) begin
      bus.excTaken  = 1'b1;
      bus.excTarget = w_epc_out;
    end else if (w_sys || w_irq) begin
      bus.excTaken  = 1'b1;
      bus.excTarget = EXC_VECTOR;
    end
  end

  always_comb begin
    w_cause_nxt = w_wb_cause ? bus.wbData : r_cause;
    if (w_sys)      w_cause_nxt[6:2] = EXC_SYS;
    else if (w_irq) w_cause_nxt[6:2] = EXC_INT;
  end

  // A nested SYSCALL keeps the original return address.
  always_comb begin
    w_epc_nxt = w_wb_epc ? bus.wbData : r_epc;
    if ((w_sys && (r_state == ST_RUN)) || w_irq) w_epc_nxt = bus.idPc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 32'h0;
      r_status_ie <= 1'b0;
      r_status_hi <= '0;
      r_cause     <= 32'h0;
      r_epc       <= 32'h0;
    end else begin
      r_count <= w_wb_count ? bus.wbData : r_count + 32'd1;
      if (w_wb_status) begin
        r_status_ie <= bus.wbData[0];
        r_status_hi <= bus.wbData[31:2];
      end
      r_cause <= w_cause_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rdSel == 3'd0) begin
      case (bus.rdCs)
        CS_COUNT:  bus.rdata = r_count;
        CS_STATUS: bus.rdata = w_status;
        CS_CAUSE:  bus.rdata = r_cause;
        CS_EPC:    bus.rdata = r_epc;
        default:   bus.rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed and randomized bench for cp0_regs against an architectural register model.
module tb_cp0_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] m_count, m_status, m_cause, m_epc;
  logic        obs_taken;
  logic [31:0] obs_target;

  cp0_regs_if bus ();
  cp0_regs dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] cs, input logic [2:0] sel);
    if (sel != 3'd0) return 32'h0;
    case (cs)
      5'd9:    return m_count;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_status = 0; m_cause = 0; m_epc = 0;
  endtask

  // One pipeline cycle: drive at negedge, check combinational outputs, then commit the model.
  task automatic cyc(input logic [2:0] op, input logic [31:0] pc, input logic [1:0] fwd,
                     input logic [31:0] exd, input logic [31:0] memd, input logic we,
                     input logic [4:0] wcs, input logic [2:0] wsel, input logic [31:0] wd,
                     input logic irq, input logic [4:0] rcs, input logic [2:0] rsel);
    logic        eret, sys, take_irq, e_taken;
    logic [31:0] epc_o, e_tgt, n_count, n_status, n_cause, n_epc;
    @(negedge clk);
    bus.idCp0Op = op; bus.idPc = pc; bus.cp0Forward = fwd;
    bus.exFwdData = exd; bus.memFwdData = memd;
    bus.wbWe = we; bus.wbCs = wcs; bus.wbSel = wsel; bus.wbData = wd;
    bus.intReq = irq; bus.rdCs = rcs; bus.rdSel = rsel;
    #1;
    eret     = (op == 3'b100);
    sys      = (op == 3'b011);
    take_irq = irq && m_status[0] && !m_status[1] && (op == 3'b000);
    epc_o    = (fwd == 2'b01) ? exd : (fwd == 2'b10) ? memd : m_epc;
    e_taken  = eret || sys || take_irq;
    e_tgt    = eret ? epc_o : (sys || take_irq) ? 32'h0000_8000 : 32'h0;
    obs_taken  = bus.excTaken;
    obs_target = bus.excTarget;
    chk("excTaken", {31'b0, obs_taken}, {31'b0, e_taken});
    chk("excTarget", obs_target, e_tgt);
    chk("rdata", bus.rdata, m_rd(rcs, rsel));
    chk("statusOut", bus.statusOut, m_status);
    n_count = m_count + 1; n_status = m_status; n_cause = m_cause; n_epc = m_epc;
    if (we && wsel == 3'd0) begin
      if (wcs == 5'd9)  n_count  = wd;
      if (wcs == 5'd12) n_status = wd;
      if (wcs == 5'd13) n_cause  = wd;
      if (wcs == 5'd14) n_epc    = wd;
    end
    if (eret) n_status[1] = 1'b0;
    else if (sys) begin
      n_cause[6:2] = 5'd8;
      if (!m_status[1]) n_epc = pc;
      n_status[1] = 1'b1;
    end else if (take_irq) begin
      n_cause[6:2] = 5'd0;
      n_epc = pc;
      n_status[1] = 1'b1;
    end
    @(posedge clk);
    m_count = n_count; m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic idle();
    cyc(3'b000, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd9, 3'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] cs, input logic [31:0] exp);
    bus.rdCs = cs; bus.rdSel = 3'd0;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  initial begin
    logic [2:0] ops [8];
    logic [4:0] cs_pick;
    ops = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b100, 3'b010, 3'b001, 3'b101};
    bus.idCp0Op = 0; bus.idPc = 0; bus.cp0Forward = 0; bus.exFwdData = 0;
    bus.memFwdData = 0; bus.wbWe = 0; bus.wbCs = 0; bus.wbSel = 0; bus.wbData = 0;
    bus.intReq = 0; bus.rdCs = 0; bus.rdSel = 0;
    model_reset();
    #2;
    chk("rst_excTaken", {31'b0, bus.excTaken}, 32'h0);
    chk("rst_statusOut", bus.statusOut, 32'h0);
    rd_chk("rst_count", 5'd9, 32'h0);
    rd_chk("rst_epc", 5'd14, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    repeat (5) idle();
    rd_chk("count_after_5", 5'd9, 32'd5);

    cyc(3'b011, 32'h40, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd13, 3'd0);
    chk("sys_taken", {31'b0, obs_taken}, 32'd1);
    chk("sys_target", obs_target, 32'h0000_8000);
    rd_chk("sys_epc", 5'd14, 32'h40);
    bus.rdCs = 5'd13; #1;
    chk("sys_exccode", {27'b0, bus.rdata[6:2]}, 32'd8);
    chk("sys_exl", {31'b0, bus.statusOut[1]}, 32'd1);

    cyc(3'b100, 32'h0, 2'b01, 32'h100, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd14, 3'd0);
    chk("eret_target", obs_target, 32'h100);
    #1 chk("eret_exl", {31'b0, bus.statusOut[1]}, 32'd0);

    cyc(3'b010, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 5'd12, 3'd0, 32'h1, 1'b0, 5'd12, 3'd0);
    #1 chk("ie_set", bus.statusOut, 32'h1);
    cyc(3'b000, 32'h80, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b1, 5'd14, 3'd0);
    chk("int_taken", {31'b0, obs_taken}, 32'd1);
    chk("int_target", obs_target, 32'h0000_8000);
    rd_chk("int_epc", 5'd14, 32'h80);
    cyc(3'b000, 32'h90, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b1, 5'd14, 3'd0);
    chk("int_masked_exl", {31'b0, obs_taken}, 32'd0);

    cyc(3'b100, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd14, 3'd0);
    chk("eret_stored_epc", obs_target, 32'h80);
    cyc(3'b011, 32'h44, 2'b00, 32'h0, 32'h0, 1'b1, 5'd14, 3'd0, 32'h200, 1'b0, 5'd14, 3'd0);
    rd_chk("sys_beats_wb_epc", 5'd14, 32'h44);
    cyc(3'b011, 32'h99, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd14, 3'd0);
    chk("nested_sys_taken", {31'b0, obs_taken}, 32'd1);
    rd_chk("nested_sys_epc_kept", 5'd14, 32'h44);

    @(negedge clk);
    bus.idCp0Op = 3'b011; bus.intReq = 1'b1; rst = 1'b1;
    #1;
    model_reset();
    chk("rst_exc_taken", {31'b0, bus.excTaken}, 32'h0);
    chk("rst_exc_target", bus.excTarget, 32'h0);
    chk("rst_exc_status", bus.statusOut, 32'h0);
    rd_chk("rst_exc_count", 5'd9, 32'h0);
    rd_chk("rst_exc_cause", 5'd13, 32'h0);
    rd_chk("rst_exc_epc", 5'd14, 32'h0);
    @(posedge clk); #1;
    bus.idCp0Op = 3'b000; bus.intReq = 1'b0; rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: cs_pick = 5'd9;
        1: cs_pick = 5'd12;
        2: cs_pick = 5'd13;
        3: cs_pick = 5'd14;
        default: cs_pick = 5'($urandom);
      endcase
      cyc(ops[$urandom_range(0, 7)], $urandom, 2'($urandom), $urandom, $urandom,
          1'($urandom), cs_pick, ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0,
          ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom, 1'($urandom),
          ($urandom_range(0, 1) == 0) ? 5'(9 + $urandom_range(0, 5)) : 5'($urandom),
          ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; every register updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port idCp0Op, input, 3 bits: ID-stage CP0 op; 000 none, 011 SYSCALL, 100 ERET, other codes no action here.
REQ-004 SHALL have port idPc, input, 32 bits: PC of the ID-stage instruction.
REQ-005 SHALL have port cp0Forward, input, 2 bits: EPC source; 01 EX, 10 MEM, 11 SYSCALL, 00 none.
REQ-006 SHALL have ports exFwdData and memFwdData, input, 32 bits each: in-flight MTC0 data from EX and MEM.
REQ-007 SHALL have ports wbWe (1 bit), wbCs (5 bits), wbSel (3 bits) and wbData (32 bits), all inputs: the WB-stage MTC0 commit.
REQ-008 SHALL have ports rdCs (5 bits) and rdSel (3 bits), inputs: the MFC0 read address.
REQ-009 SHALL have port rdata, output, 32 bits: MFC0 read data.
REQ-010 SHALL have port intReq, input, 1 bit: level-sensitive external interrupt request.
REQ-011 SHALL have port excTaken, output, 1 bit: PC redirect and IF/ID flush this cycle.
REQ-012 SHALL have port excTarget, output, 32 bits: redirect PC.
REQ-013 SHALL have port statusOut, output, 32 bits: current Status register.

Function
REQ-014 SHALL hold four registers with sel 0: Count (cs 9), Status (cs 12), Cause (cs 13) and EPC (cs 14).
REQ-015 Count SHALL increment by 1 every cycle, wrap from FFFF_FFFF to 0, and accept MTC0 writes, the write winning over the increment.
REQ-016 Status SHALL use bit0 IE and bit1 EXL; other bits SHALL be writable storage.
REQ-017 Cause ExcCode SHALL occupy bits 6:2: 8 for SYSCALL, 0 for interrupt.
REQ-018 rdata SHALL be a combinational read of the addressed register; an unmapped cs/sel SHALL return 0; rdata SHALL not bypass a same-cycle WB write.
REQ-019 epcOut SHALL be an internal signal equal to exFwdData when cp0Forward=01, memFwdData when 10, and stored EPC otherwise.
REQ-020 The FSM SHALL have two states: RUN (EXL=0) and EXC (EXL=1); the state SHALL equal Status.EXL.
REQ-021 ERET in any state: excTaken=1 and excTarget=epcOut in the same cycle; EXL SHALL clear at the next edge.
REQ-022 SYSCALL in RUN: excTaken=1 and excTarget=32'h0000_8000; at the next edge EPC<=idPc, ExcCode<=8, EXL<=1.
REQ-023 SYSCALL in EXC: redirect SHALL still occur and ExcCode SHALL update, but EPC SHALL NOT be overwritten.
REQ-024 An interrupt SHALL be taken when intReq=1, IE=1, EXL=0 and idCp0Op=000: redirect to 32'h0000_8000, EPC<=idPc, ExcCode<=0, EXL<=1.
REQ-025 Priority SHALL be ERET > SYSCALL > interrupt > WB MTC0 for any register field the higher event also updates; non-conflicting fields from the WB write SHALL still commit.
REQ-026 When no event occurs, excTaken SHALL be 0 and excTarget SHALL be 0.

Reset
REQ-027 rst=1 SHALL immediately clear Count, Status, Cause and EPC to 0; outputs SHALL follow combinationally (excTaken=0, statusOut=0).
REQ-028 Reset asserted mid-exception SHALL return the FSM to RUN with no pending redirect.

Structure
REQ-029 Opcode constants (ERET, MTC0, SYSCALL), CP0 register numbers, the ExcCode values and the vector address SHALL live in the shared CP0 definitions package.
REQ-030 The epcOut select mux SHALL be a sub-module named cp0_epc_mux; the rest SHALL be flat.

Verification
REQ-031 Reset, then idle 5 cycles -> Count=5 and rdata(cs 9)=5.
REQ-032 SYSCALL with idPc=0x0000_0040 in RUN -> excTaken=1, excTarget=0x8000; next cycle EPC=0x40, Cause[6:2]=8, statusOut[1]=1.
REQ-033 ERET with cp0Forward=01 and exFwdData=0x0000_0100 -> excTarget=0x100 the same cycle; EXL=0 next cycle.
REQ-034 intReq=1, IE=1, EXL=0, idPc=0x80 -> redirect to 0x8000 and EPC=0x80; a second intReq while EXL=1 -> no redirect.
REQ-035 WB MTC0 to EPC (0x200) in the same cycle as SYSCALL at idPc=0x44 in RUN -> EPC=0x44.
REQ-036 Assert rst during EXC -> all registers 0 and excTaken=0 immediately.
